// File: rtl/regfile_pkg.sv
// Shared register-file constants and the dump sequencer state encoding.
package regfile_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND_LO,
        ST_SEND_HI,
        ST_DONE
    } dump_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_dump_reader.sv
// Debug read-out sequencer: snapshots the register file two registers at a
// time through both read ports and streams (address, data) beats over a
// valid/ready interface while holding the core's register writes frozen.
module regfile_dump_reader #(
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              freeze,
    output logic              done,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    import regfile_pkg::*;

    dump_state_t       state;
    dump_state_t       state_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_hi;
    logic [DATA_W-1:0] buf_lo;
    logic [DATA_W-1:0] buf_hi;
    logic              last_pair;

    // idx is always even, so setting the LSB gives idx+1 without any carry
    assign idx_hi    = idx | ADDR_W'(1);
    assign last_pair = (idx == ADDR_W'(NUM_REGS - 2));
    assign freeze    = busy;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pair index and the snapshot buffers captured at the FETCH edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            buf_lo <= '0;
            buf_hi <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx <= '0;
                    end
                end
                ST_FETCH: begin
                    buf_lo <= rf_rdata1;
                    buf_hi <= rf_rdata2;
                end
                ST_SEND_HI: begin
                    if (out_ready && !last_pair) begin
                        idx <= idx + ADDR_W'(2);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode; outputs depend on state only
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        out_valid  = 1'b0;
        out_addr   = '0;
        out_data   = '0;
        rf_raddr1  = idx;
        rf_raddr2  = idx_hi;
        case (state)
            ST_IDLE: begin
                rf_raddr1 = '0;
                rf_raddr2 = '0;
                if (start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy       = 1'b1;
                state_next = ST_SEND_LO;
            end
            ST_SEND_LO: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_addr  = idx;
                out_data  = buf_lo;
                if (out_ready) begin
                    state_next = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_addr  = idx_hi;
                out_data  = buf_hi;
                if (out_ready) begin
                    state_next = last_pair ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                rf_raddr1  = '0;
                rf_raddr2  = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule : regfile_dump_reader
